zx_keyboard: RTL and testbench

- Consumes the PS/2 key event stream (strobe, make/break, set-2 scan code) from the host-interface stage and maintains a virtual 8x5 ZX Spectrum keyboard matrix.
- The ULA port-FE read path drives the high address byte and gets the 5 active-low column bits back.
- Compound PC keys (cursors, backspace, Esc, punctuation) press two matrix keys at once without disturbing keys held independently.

---
 rtl/zx_keyboard_pkg.sv | 155 +++++++++++++++
 rtl/zx_keyboard_decode.sv | 49 ++++
 rtl/zx_keyboard.sv | 110 +++++++++++
 tb/tb_zx_keyboard.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zx_keyboard_pkg.sv
// zx_keyboard_pkg: PS/2 set-2 scan-code map table and matrix-position encoding.
// Define ZX_KEYBOARD_KEMPSTON_EN to route arrows/RAlt to the Kempston port.
package zx_keyboard_pkg;

    localparam int NROWS = 8;
    localparam int NCOLS = 5;
    localparam int NMAT  = NROWS * NCOLS;
    localparam int NTAB  = 53;

`ifdef ZX_KEYBOARD_KEMPSTON_EN
    localparam int NKEYS = 53;
`else
    localparam int NKEYS = 52;
`endif

    typedef logic [5:0] pos_t;
    typedef logic [5:0] idx_t;

    typedef struct packed {
        logic valid;
        idx_t idx;
        pos_t pos_a;
        pos_t pos_b;
    } key_map_t;

    localparam pos_t POS_NONE = 6'h3F;
    localparam pos_t POS_KEMP = 6'd40;
    localparam pos_t POS_END  = 6'd45;
    localparam pos_t KEMP_R   = 6'd40;
    localparam pos_t KEMP_L   = 6'd41;
    localparam pos_t KEMP_D   = 6'd42;
    localparam pos_t KEMP_U   = 6'd43;
    localparam pos_t KEMP_F   = 6'd44;

    localparam int K_A     = 0;
    localparam int K_0     = 26;
    localparam int K_ENTER = 36;
    localparam int K_SPACE = 37;
    localparam int K_SHIFT = 38;
    localparam int K_CTRL  = 39;
    localparam int K_BKSP  = 40;
    localparam int K_ESC   = 41;
    localparam int K_LEFT  = 42;
    localparam int K_RALT  = 52;

    function automatic pos_t mpos(input int r, input int c);
        return pos_t'(r * NCOLS + c);
    endfunction

    localparam pos_t CS = 6'd0;
    localparam pos_t SS = 6'd36;

`ifdef ZX_KEYBOARD_KEMPSTON_EN
    localparam pos_t LEFT_A  = KEMP_L;
    localparam pos_t LEFT_B  = POS_NONE;
    localparam pos_t DOWN_A  = KEMP_D;
    localparam pos_t DOWN_B  = POS_NONE;
    localparam pos_t UP_A    = KEMP_U;
    localparam pos_t UP_B    = POS_NONE;
    localparam pos_t RIGHT_A = KEMP_R;
    localparam pos_t RIGHT_B = POS_NONE;
`else
    localparam pos_t LEFT_A  = CS;
    localparam pos_t LEFT_B  = mpos(3, 4);
    localparam pos_t DOWN_A  = CS;
    localparam pos_t DOWN_B  = mpos(4, 4);
    localparam pos_t UP_A    = CS;
    localparam pos_t UP_B    = mpos(4, 3);
    localparam pos_t RIGHT_A = CS;
    localparam pos_t RIGHT_B = mpos(4, 2);
`endif

    // {scan code, first matrix key, second matrix key}; both shifts share K_SHIFT
    localparam logic [19:0] MAP_TBL [NTAB] = '{
        {8'h1C, mpos(1, 0), POS_NONE},
        {8'h32, mpos(7, 4), POS_NONE},
        {8'h21, mpos(0, 3), POS_NONE},
        {8'h23, mpos(1, 2), POS_NONE},
        {8'h24, mpos(2, 2), POS_NONE},
        {8'h2B, mpos(1, 3), POS_NONE},
        {8'h34, mpos(1, 4), POS_NONE},
        {8'h33, mpos(6, 4), POS_NONE},
        {8'h43, mpos(5, 2), POS_NONE},
        {8'h3B, mpos(6, 3), POS_NONE},
        {8'h42, mpos(6, 2), POS_NONE},
        {8'h4B, mpos(6, 1), POS_NONE},
        {8'h3A, mpos(7, 2), POS_NONE},
        {8'h31, mpos(7, 3), POS_NONE},
        {8'h44, mpos(5, 1), POS_NONE},
        {8'h4D, mpos(5, 0), POS_NONE},
        {8'h15, mpos(2, 0), POS_NONE},
        {8'h2D, mpos(2, 3), POS_NONE},
        {8'h1B, mpos(1, 1), POS_NONE},
        {8'h2C, mpos(2, 4), POS_NONE},
        {8'h3C, mpos(5, 3), POS_NONE},
        {8'h2A, mpos(0, 4), POS_NONE},
        {8'h1D, mpos(2, 1), POS_NONE},
        {8'h22, mpos(0, 2), POS_NONE},
        {8'h35, mpos(5, 4), POS_NONE},
        {8'h1A, mpos(0, 1), POS_NONE},
        {8'h45, mpos(4, 0), POS_NONE},
        {8'h16, mpos(3, 0), POS_NONE},
        {8'h1E, mpos(3, 1), POS_NONE},
        {8'h26, mpos(3, 2), POS_NONE},
        {8'h25, mpos(3, 3), POS_NONE},
        {8'h2E, mpos(3, 4), POS_NONE},
        {8'h36, mpos(4, 4), POS_NONE},
        {8'h3D, mpos(4, 3), POS_NONE},
        {8'h3E, mpos(4, 2), POS_NONE},
        {8'h46, mpos(4, 1), POS_NONE},
        {8'h5A, mpos(6, 0), POS_NONE},
        {8'h29, mpos(7, 0), POS_NONE},
        {8'h12, CS,         POS_NONE},
        {8'h14, SS,         POS_NONE},
        {8'h66, CS,         mpos(4, 0)},
        {8'h76, CS,         mpos(7, 0)},
        {8'h6B, LEFT_A,     LEFT_B},
        {8'h72, DOWN_A,     DOWN_B},
        {8'h75, UP_A,       UP_B},
        {8'h74, RIGHT_A,    RIGHT_B},
        {8'h41, SS,         mpos(7, 3)},
        {8'h49, SS,         mpos(7, 2)},
        {8'h4E, SS,         mpos(6, 3)},
        {8'h55, SS,         mpos(6, 1)},
        {8'h4C, SS,         mpos(5, 1)},
        {8'h4A, SS,         mpos(0, 4)},
        {8'h11, KEMP_F,     POS_NONE}
    };

    function automatic pos_t pos_a_of(input int i);
        return MAP_TBL[i][11:6];
    endfunction

    function automatic pos_t pos_b_of(input int i);
        return MAP_TBL[i][5:0];
    endfunction

    function automatic key_map_t key_map(input logic [7:0] code);
        key_map_t m;
        m       = '0;
        m.pos_a = POS_NONE;
        m.pos_b = POS_NONE;
        for (int i = 0; i < NKEYS; i++) begin
            if (!m.valid && (MAP_TBL[i][19:12] == code ||
                (i == K_SHIFT && code == 8'h59))) begin
                m.valid = 1'b1;
                m.idx   = idx_t'(i);
                m.pos_a = pos_a_of(i);
                m.pos_b = pos_b_of(i);
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/zx_keyboard_decode.sv
// zx_keyboard_decode: registered stage 1, scan code -> table index/valid/press.
// Table contents follow ZX_KEYBOARD_KEMPSTON_EN via the package.
module zx_keyboard_decode
    import zx_keyboard_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       strb_i,
    input  logic       make_i,
    input  logic [7:0] code_i,
    input  logic       clr_i,
    output idx_t       idx_o,
    output logic       valid_o,
    output logic       press_o
);

    key_map_t m;
    idx_t     idx_d, idx_q;
    logic     valid_d, valid_q;
    logic     press_d, press_q;
    logic     unused_pos;

    // clr wins over a coincident strobe
    always_comb begin
        m       = key_map(code_i);
        idx_d   = m.idx;
        valid_d = strb_i & m.valid & ~clr_i;
        press_d = ~make_i;
    end

    assign unused_pos = ^{m.pos_a, m.pos_b};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            idx_q   <= '0;
            valid_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            valid_q <= valid_d;
            press_q <= press_d;
        end
    end

    assign idx_o   = idx_q;
    assign valid_o = valid_q;
    assign press_o = press_q;

endmodule

// File: rtl/zx_keyboard.sv
// zx_keyboard: PS/2 events -> held-entry vector -> 8x5 ZX Spectrum matrix.
// Define ZX_KEYBOARD_KEMPSTON_EN to add the kemp joystick output.
module zx_keyboard
    import zx_keyboard_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       strb,
    input  logic       make,
    input  logic [7:0] code,
    input  logic       clr,
    input  logic [7:0] addr,
    output logic [4:0] col,
    output logic       held_any
`ifdef ZX_KEYBOARD_KEMPSTON_EN
    ,
    output logic [4:0] kemp
`endif
);

    idx_t             s1_idx;
    logic             s1_valid;
    logic             s1_press;
    logic [NKEYS-1:0] held_d, held_q;
    logic [NMAT-1:0]  matrix_d, matrix_q;
    logic             any_d, any_q;
    logic [4:0]       sel;
    pos_t             p;
`ifdef ZX_KEYBOARD_KEMPSTON_EN
    logic [4:0]       kemp_d, kemp_q;
`endif

    zx_keyboard_decode u_decode (
        .clock   (clock),
        .reset   (reset),
        .strb_i  (strb),
        .make_i  (make),
        .code_i  (code),
        .clr_i   (clr),
        .idx_o   (s1_idx),
        .valid_o (s1_valid),
        .press_o (s1_press)
    );

    always_comb begin
        held_d = held_q;
        if (clr) begin
            held_d = '0;
        end else if (s1_valid) begin
            held_d[s1_idx] = s1_press;
        end
    end

    // Each target is the OR of every held entry that reaches it
    always_comb begin
        matrix_d = '0;
`ifdef ZX_KEYBOARD_KEMPSTON_EN
        kemp_d   = '0;
`endif
        p        = POS_NONE;
        for (int i = 0; i < NKEYS; i++) begin
            for (int k = 0; k < 2; k++) begin
                p = (k == 0) ? pos_a_of(i) : pos_b_of(i);
                if (held_q[i] && p < POS_KEMP) begin
                    matrix_d[p] = 1'b1;
                end
`ifdef ZX_KEYBOARD_KEMPSTON_EN
                if (held_q[i] && p >= POS_KEMP && p < POS_END) begin
                    kemp_d[3'(p - POS_KEMP)] = 1'b1;
                end
`endif
            end
        end
        any_d = |held_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            held_q   <= '0;
            matrix_q <= '0;
            any_q    <= 1'b0;
`ifdef ZX_KEYBOARD_KEMPSTON_EN
            kemp_q   <= '0;
`endif
        end else begin
            held_q   <= held_d;
            matrix_q <= matrix_d;
            any_q    <= any_d;
`ifdef ZX_KEYBOARD_KEMPSTON_EN
            kemp_q   <= kemp_d;
`endif
        end
    end

    always_comb begin
        sel = '0;
        for (int r = 0; r < NROWS; r++) begin
            if (!addr[r]) begin
                sel = sel | matrix_q[r*NCOLS +: NCOLS];
            end
        end
        col = ~sel;
    end

    assign held_any = any_q;
`ifdef ZX_KEYBOARD_KEMPSTON_EN
    assign kemp     = kemp_q;
`endif

endmodule

// File: tb/tb_zx_keyboard.sv
// tb_zx_keyboard: scoreboard bench with a name-based keyboard model.
// Honours ZX_KEYBOARD_KEMPSTON_EN the same way as the design.
`timescale 1ns/1ps
module tb_zx_keyboard;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       strb  = 1'b0;
    logic       make  = 1'b0;
    logic       clr   = 1'b0;
    logic [7:0] code  = 8'h00;
    logic [7:0] addr  = 8'hFF;
    logic [4:0] col;
    logic       held_any;
`ifdef ZX_KEYBOARD_KEMPSTON_EN
    logic [4:0] kemp;
`endif

    zx_keyboard dut (
        .clock    (clock),
        .reset    (reset),
        .strb     (strb),
        .make     (make),
        .code     (code),
        .clr      (clr),
        .addr     (addr),
        .col      (col),
        .held_any (held_any)
`ifdef ZX_KEYBOARD_KEMPSTON_EN
        ,
        .kemp     (kemp)
`endif
    );

    always #20 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0]     due;
        logic [7:0][4:0] rows;
        logic            any;
        logic [4:0]      kemp;
    } snap_t;

    snap_t sbq[$];
    int    total = 0;
    int    bad   = 0;

    string layout [8][5] = '{
        '{"CS", "Z", "X", "C", "V"},
        '{"A", "S", "D", "F", "G"},
        '{"Q", "W", "E", "R", "T"},
        '{"1", "2", "3", "4", "5"},
        '{"0", "9", "8", "7", "6"},
        '{"P", "O", "I", "U", "Y"},
        '{"ENTER", "L", "K", "J", "H"},
        '{"SPACE", "SS", "M", "N", "B"}
    };
    string kname [5] = '{"KR", "KL", "KD", "KU", "KF"};

    string      cent [bit [7:0]];
    string      ek1 [string];
    string      ek2 [string];
    bit         held [string];
    bit [7:0]   codes[$];

    function automatic void add(bit [7:0] c, string e, string k1, string k2);
        cent[c] = e;
        ek1[e]  = k1;
        ek2[e]  = k2;
        codes.push_back(c);
    endfunction

    function automatic void build();
        string letters;
        string digits;
        bit [7:0] lc [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B,
            8'h34, 8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
            8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A,
            8'h1D, 8'h22, 8'h35, 8'h1A};
        bit [7:0] dc [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E,
            8'h36, 8'h3D, 8'h3E, 8'h46};
        letters = "ABCDEFGHIJKLMNOPQRSTUVWXYZ";
        digits  = "0123456789";
        for (int i = 0; i < 26; i++)
            add(lc[i], letters.substr(i, i), letters.substr(i, i), "");
        for (int i = 0; i < 10; i++)
            add(dc[i], digits.substr(i, i), digits.substr(i, i), "");
        add(8'h5A, "ENTER", "ENTER", "");
        add(8'h29, "SPACE", "SPACE", "");
        add(8'h12, "SHIFT", "CS", "");
        add(8'h59, "SHIFT", "CS", "");
        add(8'h14, "CTRL", "SS", "");
        add(8'h66, "BKSP", "CS", "0");
        add(8'h76, "ESC", "CS", "SPACE");
`ifdef ZX_KEYBOARD_KEMPSTON_EN
        add(8'h6B, "LEFT", "KL", "");
        add(8'h72, "DOWN", "KD", "");
        add(8'h75, "UP", "KU", "");
        add(8'h74, "RIGHT", "KR", "");
        add(8'h11, "RALT", "KF", "");
`else
        add(8'h6B, "LEFT", "CS", "5");
        add(8'h72, "DOWN", "CS", "6");
        add(8'h75, "UP", "CS", "7");
        add(8'h74, "RIGHT", "CS", "8");
`endif
        add(8'h41, "COMMA", "SS", "N");
        add(8'h49, "DOT", "SS", "M");
        add(8'h4E, "MINUS", "SS", "J");
        add(8'h55, "EQUALS", "SS", "L");
        add(8'h4C, "SEMI", "SS", "O");
        add(8'h4A, "SLASH", "SS", "V");
    endfunction

    function automatic snap_t snap(int due);
        bit    pr [string];
        snap_t s;
        s     = '0;
        s.due = due;
        foreach (held[e]) begin
            pr[ek1[e]] = 1'b1;
            if (ek2[e] != "") pr[ek2[e]] = 1'b1;
        end
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 5; c++)
                if (pr.exists(layout[r][c])) s.rows[r][c] = 1'b1;
        for (int b = 0; b < 5; b++)
            if (pr.exists(kname[b])) s.kemp[b] = 1'b1;
        s.any = (held.num() > 0);
        return s;
    endfunction

    // A later snapshot due no later than a queued one supersedes it
    function automatic void push_snap(int due);
        while (sbq.size() > 0 && int'(sbq[$].due) >= due)
            void'(sbq.pop_back());
        sbq.push_back(snap(due));
    endfunction

    task automatic drive(bit s, bit m, bit [7:0] c, bit cl);
        @(negedge clock);
        strb = s;
        make = m;
        code = c;
        clr  = cl;
        if (cl) begin
            held.delete();
            push_snap(cyc + 2);
        end else if (s && cent.exists(c)) begin
            if (!m) held[cent[c]] = 1'b1;
            else if (held.exists(cent[c])) held.delete(cent[c]);
            push_snap(cyc + 3);
        end
    endtask

    task automatic idle(int n);
        repeat (n) drive(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        strb  = 1'b0;
        clr   = 1'b0;
        held.delete();
        sbq.delete();
        push_snap(cyc + 1);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        push_snap(cyc + 1);
    endtask

    task automatic check(snap_t s);
        logic [7:0] al [11];
        logic [4:0] exp;
        al = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F,
               8'hFF, 8'hF9, 8'($urandom)};
        for (int i = 0; i < 11; i++) begin
            addr = al[i];
            #1;
            exp = 5'h1F;
            for (int r = 0; r < 8; r++)
                if (!al[i][r]) exp = exp & ~s.rows[r];
            total++;
            if (col !== exp) begin
                bad++;
                $display("FAIL col addr=%h cyc=%0d got=%h want=%h",
                         al[i], cyc, col, exp);
            end
        end
        total++;
        if (held_any !== s.any) begin
            bad++;
            $display("FAIL held_any cyc=%0d got=%b want=%b",
                     cyc, held_any, s.any);
        end
`ifdef ZX_KEYBOARD_KEMPSTON_EN
        total++;
        if (kemp !== s.kemp) begin
            bad++;
            $display("FAIL kemp cyc=%0d got=%h want=%h", cyc, kemp, s.kemp);
        end
`endif
    endtask

    initial begin
        forever begin
            @(negedge clock);
            while (sbq.size() > 0 && int'(sbq[0].due) < cyc) begin
                total++;
                bad++;
                $display("FAIL missed due=%0d got_cyc=%0d want_cyc=%0d",
                         sbq[0].due, cyc, sbq[0].due);
                void'(sbq.pop_front());
            end
            if (sbq.size() > 0 && int'(sbq[0].due) == cyc)
                check(sbq.pop_front());
        end
    end

    initial begin
        int r;
        build();
        do_reset();
        idle(2);

        drive(1, 0, 8'h1C, 0); idle(3);
        drive(1, 1, 8'h1C, 0); idle(3);

        drive(1, 0, 8'h66, 0); idle(3);
        drive(1, 0, 8'h12, 0);
        drive(1, 1, 8'h66, 0); idle(3);
        drive(1, 1, 8'h12, 0); idle(3);

        drive(1, 0, 8'h1C, 0);
        drive(1, 0, 8'h15, 0); idle(3);
        drive(1, 1, 8'h1C, 0);
        drive(1, 1, 8'h15, 0); idle(3);

        repeat (3) drive(1, 0, 8'h2D, 0);
        idle(1);
        drive(1, 1, 8'h2D, 0); idle(3);

        drive(1, 1, 8'h1A, 0);
        drive(1, 0, 8'h11, 0);
        drive(1, 0, 8'h07, 0); idle(3);

        drive(1, 0, 8'h41, 0); idle(3);
        drive(1, 0, 8'h31, 1); idle(3);

`ifdef ZX_KEYBOARD_KEMPSTON_EN
        drive(1, 0, 8'h6B, 0); idle(3);
        drive(1, 0, 8'h11, 0); idle(3);
        drive(1, 1, 8'h6B, 0);
        drive(1, 1, 8'h11, 0); idle(3);
`endif

        drive(1, 0, 8'h59, 0); idle(1);
        drive(1, 0, 8'h12, 0); idle(3);
        drive(1, 1, 8'h59, 0); idle(3);

        drive(1, 0, 8'h1C, 0);
        do_reset();
        idle(4);

        for (int i = 0; i < 900; i++) begin
            r = $urandom_range(0, 99);
            if (i == 450) do_reset();
            if (r < 3)
                drive(1'($urandom), 1'b0, codes[$urandom_range(0,
                      codes.size() - 1)], 1'b1);
            else if (r < 92)
                drive(1'b1, ($urandom_range(0, 99) < 45),
                      codes[$urandom_range(0, codes.size() - 1)], 1'b0);
            else
                drive(1'b1, 1'($urandom), 8'($urandom), 1'b0);
            idle($urandom_range(0, 2));
        end

        idle(1);
        for (int k = 0; k < 10 && sbq.size() > 0; k++) @(negedge clock);
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d want=0 pending", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
